mux_rr_arbiter: RTL and testbench

- Round-robin scheduler that shares one 8:1 bit multiplexer among 8 requesters.
- Drives the mux select lines and a one-hot grant vector.
- Enforces a maximum hold time (quantum) per grant and a one-cycle dead gap between owners so the mux never switches mid-grant.
- Sits directly in front of the 8:1 mux; select connects straight to its select input.

---
 rtl/mux_rr_arbiter_if.sv | 20 ++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin mux arbiter.
// The arbiter takes the slave side; the requesters take the master side.
interface mux_rr_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] select;
    logic       sel_valid;
    logic       expire;

    modport master (
        output en, req,
        input  gnt, select, sel_valid, expire
    );

    modport slave (
        input  en, req,
        output gnt, select, sel_valid, expire
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner scheduler for an 8:1 bit mux. It limits each grant to a
// quantum and forces one dead cycle between owners.
module mux_rr_arbiter #(
    parameter int unsigned N_REQ   = 8,
    parameter int unsigned QUANTUM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state, state_n;
    logic [7:0] gnt_q, gnt_n;
    logic [2:0] select_q, select_n;
    logic       sel_valid_q, sel_valid_n;
    logic       expire_q, expire_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] win, cand;
    logic       win_ok;

    // First requester at or after ptr, wrapping modulo 8
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + 3'(i);
            if (!win_ok && bus.req[cand]) begin
                win    = cand;
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt_q;
        select_n    = select_q;
        sel_valid_n = sel_valid_q;
        expire_n    = 1'b0;
        ptr_n       = ptr;
        cnt_n       = cnt;
        case (state)
            GRANT: begin
                if (!bus.req[select_q] || cnt == 8'(QUANTUM)) begin
                    gnt_n       = '0;
                    sel_valid_n = 1'b0;
                    ptr_n       = select_q + 3'd1;
                    expire_n    = bus.req[select_q];
                    state_n     = GAP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                gnt_n       = '0;
                sel_valid_n = 1'b0;
                state_n     = IDLE;
                if (bus.en && win_ok) begin
                    gnt_n[win]  = 1'b1;
                    select_n    = win;
                    sel_valid_n = 1'b1;
                    cnt_n       = 8'd1;
                    state_n     = GRANT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_q       <= '0;
            select_q    <= '0;
            sel_valid_q <= 1'b0;
            expire_q    <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            gnt_q       <= gnt_n;
            select_q    <= select_n;
            sel_valid_q <= sel_valid_n;
            expire_q    <= expire_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.select    = select_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.expire    = expire_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: runs QUANTUM=4 and QUANTUM=1 instances in
// lockstep against an owner/hold-count/pointer schedule model.
module tb_mux_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = '0;

    int tests = 0;
    int fails = 0;

    mux_rr_arbiter_if bus4 ();
    mux_rr_arbiter_if bus1 ();

    assign bus4.en  = en;
    assign bus4.req = req;
    assign bus1.en  = en;
    assign bus1.req = req;

    mux_rr_arbiter #(.N_REQ(8), .QUANTUM(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux_rr_arbiter #(.N_REQ(8), .QUANTUM(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    logic [7:0] o_gnt [2];
    logic [2:0] o_sel [2];
    logic       o_sv  [2];
    logic       o_exp [2];
    assign o_gnt[0] = bus4.gnt;       assign o_gnt[1] = bus1.gnt;
    assign o_sel[0] = bus4.select;    assign o_sel[1] = bus1.select;
    assign o_sv[0]  = bus4.sel_valid; assign o_sv[1]  = bus1.sel_valid;
    assign o_exp[0] = bus4.expire;    assign o_exp[1] = bus1.expire;

    // Schedule model: who owns the mux, for how long, and where the scan starts
    int quantum [2] = '{4, 1};
    int owner   [2];
    int held    [2];
    int ptr_m   [2];
    int sel_m   [2];
    bit exp_m   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; held[k] = 0; ptr_m[k] = 0; sel_m[k] = 0; exp_m[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        if (owner[k] >= 0) begin
            if (!req[owner[k]] || held[k] == quantum[k]) begin
                exp_m[k]  = req[owner[k]];
                ptr_m[k]  = (owner[k] + 1) % 8;
                owner[k]  = -1;
            end else begin
                held[k]  = held[k] + 1;
                exp_m[k] = 1'b0;
            end
        end else begin
            exp_m[k] = 1'b0;
            if (en && req != 8'h00) begin
                for (int j = 0; j < 8; j++) begin
                    if (owner[k] < 0 && req[(ptr_m[k] + j) % 8]) begin
                        owner[k] = (ptr_m[k] + j) % 8;
                        held[k]  = 1;
                        sel_m[k] = owner[k];
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[q%0d] observed=%0h expected=%0h", tag, quantum[k], obs, exp);
        end
    endtask

    task automatic check_inst(input int k);
        logic [7:0] eg;
        eg = '0;
        if (owner[k] >= 0) eg[owner[k]] = 1'b1;
        chk("gnt", k, 32'(o_gnt[k]), 32'(eg));
        chk("select", k, 32'(o_sel[k]), 32'(sel_m[k]));
        chk("sel_valid", k, 32'(o_sv[k]), 32'(owner[k] >= 0));
        chk("expire", k, 32'(o_exp[k]), 32'(exp_m[k]));
        chk("onehot0", k, 32'($onehot0(o_gnt[k])), 32'd1);
        if (o_sv[k] === 1'b1) chk("gnt_at_select", k, 32'(o_gnt[k][o_sel[k]]), 32'd1);
        if (o_exp[k] === 1'b1) chk("expire_gnt_zero", k, 32'(o_gnt[k]), 32'd0);
    endtask

    task automatic step(input bit e, input logic [7:0] r);
        en  = e;
        req = r;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    // Asserts reset between edges and checks that outputs clear before any edge
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_inst(0);
        check_inst(1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        async_reset();

        // Single continuous requester: quantum, expiring gap, re-grant
        repeat (10) step(1'b1, 8'h04);

        // Early release
        async_reset();
        repeat (2) step(1'b1, 8'h01);
        repeat (4) step(1'b1, 8'h00);

        // Everyone requesting: rotation 0..7 and wrap
        repeat (40) step(1'b1, 8'hFF);
        repeat (2) step(1'b1, 8'h00);

        // Pointer priority: owner 5 releases with bits 0 and 5 pending
        async_reset();
        step(1'b1, 8'h20);
        repeat (16) step(1'b1, 8'h21);
        repeat (2) step(1'b1, 8'h00);

        // Enable gating: owner 3 finishes with en low, index 4 waits for en
        async_reset();
        step(1'b1, 8'h08);
        repeat (8) step(1'b0, 8'h18);
        repeat (3) step(1'b1, 8'h18);

        // Asynchronous reset while index 7 owns the mux
        async_reset();
        repeat (2) step(1'b1, 8'h80);
        chk("gnt_before_reset", 0, 32'(o_gnt[0]), 32'h80);
        async_reset();
        repeat (3) step(1'b1, 8'h81);

        // Randomised traffic
        begin
            logic [7:0] r;
            bit e;
            r = '0;
            for (int n = 0; n < 400; n++) begin
                e = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
                if (n == 200) async_reset();
                step(e, r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
